// File: rtl/argmax_readout.sv
// -----------------------------------------------------------------------------
// argmax_readout
//
// Output stage for the layered inference network. It captures the network's
// final N-element signed activation vector on the done pulse. It then scans
// the captured copy one element per cycle to find the predicted class, which
// is the maximum element. On ties the lowest index wins. The winning index
// and value are presented on a valid/ready interface.
//
// The upstream network cannot be stalled. Any vector that arrives while this
// block cannot take it is dropped. A drop sets a sticky overrun flag and bumps
// a saturating drop counter.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   in_valid    single-cycle pulse, in_data valid (network done)
//   in_data     packed vector, element k at [(k+1)*W-1 : k*W]
//   in_ready    a vector presented this cycle will be accepted
//   out_valid   result available
//   out_ready   consumer accepts the result
//   out_index   index of the maximum element
//   out_value   signed value of the maximum element
//   overrun     sticky: at least one vector was dropped
//   drop_count  saturating count of dropped vectors
// -----------------------------------------------------------------------------
module argmax_readout #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [N*W-1:0]         in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_index,
  output logic signed [W-1:0]    out_value,
  output logic                   overrun,
  output logic [7:0]             drop_count
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Private copy of the vector. in_data may change right after capture.
  logic [N*W-1:0]      shadow;
  logic signed [W-1:0] elem [N];

  logic signed [W-1:0] best_val;
  logic [CW-1:0]       best_idx;
  logic [CW-1:0]       cnt;

  logic signed [W-1:0] cur_val;
  logic signed [W-1:0] win_val;
  logic [CW-1:0]       win_idx;
  logic                last;
  logic                accept;
  logic                drop;

  // ---------------------------------------------------------------------------
  // Scan datapath: compare the current element against the running best.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      elem[k] = shadow[k*W +: W];
    end
    cur_val = elem[cnt];
    win_val = best_val;
    win_idx = best_idx;
    // Strict compare: an equal later element never replaces the earlier one.
    if (cur_val > best_val) begin
      win_val = cur_val;
      win_idx = cnt;
    end
  end

  assign last   = (cnt == LAST_IDX);
  assign accept = in_valid &  in_ready;
  assign drop   = in_valid & ~in_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // pre-edge values no matter the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = SCAN;
      SCAN: if (last)     state_nxt = DONE;
      DONE: begin
        // A new vector on the handshake edge goes straight back to SCAN.
        if (out_ready) state_nxt = in_valid ? SCAN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. in_ready must not depend on in_valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  end

  // ---------------------------------------------------------------------------
  // Capture, scan registers, result registers and drop accounting
  // ---------------------------------------------------------------------------
  // NOTE: the shadow buffer is ordinary flops, not a RAM, so it is cleared on
  // reset together with the rest of the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow     <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_value  <= '0;
      overrun    <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      // Accepts happen only in IDLE or DONE, so they never collide with SCAN.
      if (accept) begin
        shadow   <= in_data;
        best_val <= in_data[W-1:0];
        best_idx <= '0;
        cnt      <= CW'(1);
      end else if (state == SCAN) begin
        best_val <= win_val;
        best_idx <= win_idx;
        if (!last) cnt <= cnt + CW'(1);
      end

      // The result is loaded once, as the scan finishes. It then holds until
      // the handshake.
      if ((state == SCAN) && last) begin
        out_valid <= 1'b1;
        out_index <= win_idx;
        out_value <= win_val;
      end else if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_argmax_readout.sv
// -----------------------------------------------------------------------------
// tb_argmax_readout
//
// Directed bench for argmax_readout with N=4 and W=16. Inputs change 1 ns
// after a rising edge. Outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_argmax_readout;

  localparam int N = 4;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic [N*W-1:0]      in_data;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_index;
  logic signed [W-1:0] out_value;
  logic                overrun;
  logic [7:0]          drop_count;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc;

  argmax_readout #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_value  (out_value),
    .overrun    (overrun),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pack4(input int e0, input int e1,
                                           input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle in_valid pulse. in_data is then scrambled to prove isolation.
  task automatic send(input logic [N*W-1:0] v);
    in_data  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  // Counts edges until out_valid rises, bounded. Returns -1 on timeout.
  task automatic wait_valid(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int idx, input int val);
    check({tag, " out_valid"}, 32'(out_valid), 1);
    check({tag, " out_index"}, 32'(out_index), 32'(idx));
    check({tag, " out_value"}, 32'(out_value), 32'(val));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst out_valid",  32'(out_valid),  0);
    check("rst out_index",  32'(out_index),  0);
    check("rst out_value",  32'(out_value),  0);
    check("rst overrun",    32'(overrun),    0);
    check("rst drop_count", 32'(drop_count), 0);
    check("rst in_ready",   32'(in_ready),   1);

    // Basic max [10,-3,25,7] -> idx 2, value 25, 3 cycles latency
    send(pack4(10, -3, 25, 7));
    check("t1 in_ready in SCAN", 32'(in_ready), 0);
    wait_valid(cyc);
    check("t1 latency", 32'(cyc), 3);
    check_result("t1", 2, 25);
    check("t1 in_ready DONE+ready", 32'(in_ready), 1);
    tick();
    check("t1 out_valid drops", 32'(out_valid), 0);
    check("t1 back to IDLE",    32'(in_ready),  1);

    // Ties and negatives
    send(pack4(-5, -2, -9, -2));
    wait_valid(cyc);
    check("t2 latency", 32'(cyc), 3);
    check_result("t2", 1, -2);
    tick();

    // Extremes
    send(pack4(-32768, 32767, 0, 32767));
    wait_valid(cyc);
    check("t3 latency", 32'(cyc), 3);
    check_result("t3", 1, 32767);
    tick();

    // Back-pressure with a dropped vector during the wait
    out_ready = 1'b0;
    send(pack4(5, 1, 5, 0));
    wait_valid(cyc);
    check("t4 latency", 32'(cyc), 3);
    check_result("t4 first", 0, 5);
    check("t4 in_ready blocked", 32'(in_ready), 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        in_data  = pack4(1, 2, 3, 4);
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      check_result("t4 hold", 0, 5);
    end
    check("t4 overrun",    32'(overrun),    1);
    check("t4 drop_count", 32'(drop_count), 1);
    out_ready = 1'b1;
    tick();
    check("t4 handshake", 32'(out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4 dropped never appears", 32'(out_valid), 0);
    end

    // Back-to-back capture on the handshake edge, plus a drop during SCAN
    send(pack4(2, 7, 7, 1));
    wait_valid(cyc);
    check("t5 latency", 32'(cyc), 3);
    check_result("t5 first", 1, 7);
    in_data  = pack4(0, 0, 0, 9);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    check("t5 out_valid after b2b", 32'(out_valid), 0);
    check("t5 in SCAN",             32'(in_ready),  0);
    in_data  = pack4(100, 100, 100, 100);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t5 scan drop_count", 32'(drop_count), 2);
    wait_valid(cyc);
    check("t5 remaining latency", 32'(cyc), 2);
    check_result("t5 second", 3, 9);
    tick();

    // Reset mid-SCAN at cnt=2
    send(pack4(1, 2, 3, 4));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6 out_valid",  32'(out_valid),  0);
    check("t6 out_index",  32'(out_index),  0);
    check("t6 out_value",  32'(out_value),  0);
    check("t6 overrun",    32'(overrun),    0);
    check("t6 drop_count", 32'(drop_count), 0);
    check("t6 in_ready",   32'(in_ready),   1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6 no stale result", 32'(out_valid), 0);
    end
    send(pack4(4, -1, 6, 6));
    wait_valid(cyc);
    check("t6 latency", 32'(cyc), 3);
    check_result("t6 after reset", 2, 6);
    tick();

    // Drop counter saturation: 300 drops while held in DONE
    send(pack4(0, 1, 0, 0));
    wait_valid(cyc);
    check("t7 latency", 32'(cyc), 3);
    out_ready = 1'b0;
    in_data   = pack4(50, 50, 50, 50);
    in_valid  = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) check("t7 drop_count 254", 32'(drop_count), 254);
      if (i == 255) check("t7 drop_count 255", 32'(drop_count), 255);
    end
    in_valid = 1'b0;
    check("t7 drop_count sat", 32'(drop_count), 255);
    check("t7 overrun",        32'(overrun),    1);
    check_result("t7 held", 1, 1);
    out_ready = 1'b1;
    tick();
    check("t7 handshake", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/argmax_readout.md
Name: argmax_readout

Overview:
- Output stage placed directly downstream of the layered inference network.
- Captures the network's final N-element signed 16-bit activation vector when the network's done pulse fires.
- Scans the vector serially, one element per cycle, to find the maximum (the predicted class).
- Presents the class index and its value on a valid/ready interface, with overrun detection because the network has no back-pressure.

Parameters:
- N, 4, number of elements in the input vector (number of classes); N >= 2.
- W, 16, element width in bits; elements are signed two's complement.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  single-cycle pulse marking in_data valid; driven from the network's done.
- in_data  input  N*W  packed signed vector; element k occupies bits [(k+1)*W-1 : k*W].
- in_ready  output  1  high when a vector presented this cycle will be accepted.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_index  output  $clog2(N)  index of the maximum element.
- out_value  output  W  signed value of the maximum element.
- overrun  output  1  sticky flag: at least one input vector was dropped.
- drop_count  output  8  saturating count of dropped vectors.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE.
  - out_valid=0, out_index=0, out_value=0, overrun=0, drop_count=0.
  - Internal capture register and scan counter cleared.
  - Reset has priority over every other event, including mid-SCAN; the partial result is discarded and no output appears.
- States: IDLE, SCAN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational and has no dependence on in_valid.
- IDLE:
  - On in_valid=1, register all of in_data into the shadow buffer.
  - Set best_val=element 0, best_idx=0, cnt=1, then go to SCAN.
- SCAN, at each edge:
  - If signed element[cnt] > best_val (strict), set best_val=element[cnt] and best_idx=cnt.
  - If cnt==N-1, go to DONE with out_valid=1. Otherwise cnt=cnt+1.
- Ties: the lowest index wins because the comparison is strict.
- Compare is full W-bit signed. There is no saturation or truncation; out_value equals an input element bit-exactly.
- Latency: in_valid sampled at edge E0 gives out_valid=1 in the cycle after edge E0+(N-1). For N=4 that is 3 cycles.
- DONE:
  - out_index and out_value are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready, the handshake completes. If in_valid is not high on the same edge, go to IDLE and deassert out_valid on the next cycle.
  - If in_valid and out_ready are both high in DONE, the new vector is captured on that edge and the block goes directly to SCAN with no idle bubble. out_valid deasserts in the following cycle.
- Drop rule: in_valid=1 while in_ready=0 (any SCAN cycle, or DONE with out_ready=0) means:
  - The vector is ignored; the shadow buffer and the in-progress or held result are unchanged.
  - overrun is set to 1.
  - drop_count increments, saturating at 255.
- overrun and drop_count are cleared only by reset.
- The shadow buffer isolates the scan from in_data. in_data may change freely after the capture edge.
- out_index and out_value are registered outputs, with no combinational path from any input.

Test Plan:
- N=4, in_data elements [10,-3,25,7] (index 0 first), one in_valid pulse, out_ready=1:
  - out_valid high exactly 3 cycles after the capture edge.
  - out_index=2, out_value=25.
  - out_valid held for one cycle, then IDLE.
- Ties and negatives, elements [-5,-2,-9,-2]:
  - out_index=1, out_value=-2.
  - Extremes, elements [-32768,32767,0,32767]: out_index=1, out_value=32767.
- Back-pressure with out_ready=0 for 6 cycles after out_valid:
  - Outputs stay stable.
  - An in_valid pulse with [1,2,3,4] during the wait sets overrun=1 and drop_count=1.
  - The held result is unchanged.
  - On out_ready=1 the original result is handshaked and the dropped vector never appears.
- Back-to-back, in DONE with out_ready=1 and in_valid=1 carrying [0,0,0,9]:
  - The handshake completes and the new vector is captured on the same edge.
  - Next result is out_index=3, out_value=9, 3 cycles later.
  - A pulse during SCAN increments drop_count.
- Reset mid-SCAN, rst_n=0 for 1 cycle at cnt=2:
  - All outputs return to reset values; out_valid never asserts for that vector.
  - overrun and drop_count are 0.
  - The next vector is processed normally.
- Saturation: 300 in_valid pulses while in DONE with out_ready=0 gives drop_count=255 and overrun=1.
